des_key_sched: RTL
==================

DES_KEY_SCHED -- requirements
Module: des_key_sched

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by FIPS 46-3.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 n_rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 key_load  input  1  one-cycle strobe; captures key_in and decrypt.
REQ-005 key_in  input  64  DES key; key_in[63] = FIPS bit 1, key_in[0] = FIPS bit 64; parity bits ignored.
REQ-006 decrypt  input  1  0 = subkeys K1..K16 in order, 1 = K16..K1; sampled only with key_load.
REQ-007 next_round  input  1  consumer strobe; advances to the next subkey.
REQ-008 subkey  output  48  current round subkey; subkey[47] = FIPS bit 1; subkey[47-6n -: 6] is the S-box n+1 key chunk, e.g. S-box 3 uses subkey[35:30].
REQ-009 subkey_valid  output  1  subkey is a valid round key.
REQ-010 round_num  output  4  0-based index of the presented subkey in output order (0..15).
REQ-011 busy  output  1  high while the schedule is ACTIVE.
REQ-012 done  output  1  one-cycle pulse after the 16th subkey is consumed.

Function
REQ-013 Registers SHALL be: 28-bit C, 28-bit D, 4-bit round counter, 1-bit direction, and a 2-bit state.
REQ-014 States SHALL be IDLE, ACTIVE and DONE; busy = (state==ACTIVE); subkey_valid = busy.
REQ-015 The shift table SHALL be S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-016 On key_load, in any state, the block SHALL compute {C0,D0} = PC-1(key_in), load round counter 0, latch decrypt, and enter ACTIVE.
REQ-017 For encrypt loads, C,D SHALL load rotl(C0,S[1]) and rotl(D0,S[1]); for decrypt loads, C,D SHALL load C0,D0 unrotated, which yields K16.
REQ-018 subkey SHALL equal PC-2(C,D) combinationally from the registers, so it is valid the cycle after key_load (latency 1).
REQ-019 On next_round in ACTIVE with round_num = r < 15, the counter SHALL become r+1.
REQ-020 In the same case, C and D SHALL rotate left by S[r+2] (encrypt) or right by S[16-r] (decrypt); both are 28-bit circular rotations.
REQ-021 On next_round in ACTIVE with round_num = 15, the block SHALL enter DONE and hold C, D and the counter.
REQ-022 DONE SHALL last exactly one cycle with done = 1 and subkey_valid = 0, then go to IDLE.
REQ-023 next_round in IDLE or DONE SHALL be ignored.
REQ-024 If key_load and next_round are asserted together, key_load SHALL win and next_round is dropped.
REQ-025 key_load asserted in DONE SHALL suppress the IDLE transition: the next state is ACTIVE, and done still pulses for that one cycle.
REQ-026 In IDLE, subkey SHALL still reflect PC-2(C,D) but subkey_valid = 0; consumers SHALL ignore it.
REQ-027 The rotation accumulated over a full 16-round pass SHALL be 28, so C and D return to C0 and D0 (encrypt) after round 16.

Reset
REQ-028 With n_rst = 0 at a clock edge, the block SHALL set state IDLE, C = 0, D = 0, counter 0, direction 0.
REQ-029 Reset values SHALL give subkey = 0, subkey_valid = 0, round_num = 0, busy = 0 and done = 0.
REQ-030 Reset SHALL override key_load and next_round, including mid-schedule; no done pulse is produced.
REQ-031 Between reset edges the outputs SHALL be those of the registered state; there is no asynchronous path.

Verification
REQ-032 Encrypt first subkey: key_load with key_in = 64'h133457799BBCDFF1, decrypt = 0 -> next cycle subkey = 48'h1B02EFFC7072, subkey[35:30] = 6'h0B, round_num = 0, subkey_valid = 1.
REQ-033 Encrypt walk: one next_round after REQ-032 -> subkey = 48'h79AED9DBC9E5, round_num = 1.
REQ-034 Encrypt completion: 14 further strobes -> 48'hCB3D8B0E17F5 at round_num = 15; the next strobe -> done = 1 for one cycle, subkey_valid = 0, then IDLE.
REQ-035 Decrypt order: same key with decrypt = 1 -> round_num 0 presents 48'hCB3D8B0E17F5, round 1 presents the encrypt K15, and round_num 15 presents 48'h1B02EFFC7072.
REQ-036 Boundary cases: next_round strobed in IDLE -> no state change; key_load together with next_round at round 5 -> restart at round_num 0 with K1.
REQ-037 Reset mid-run: n_rst = 0 at round 7 -> all outputs 0 the following cycle and no done pulse.

Source files
------------

// File: rtl/des_key_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : des_key_sched_if
//  Description : Key-load / subkey-consume bus for the DES key schedule.
//                The master loads a key and strobes next_round; the slave
//                presents one 48-bit round subkey at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
interface des_key_sched_if;
  logic        key_load;
  logic [63:0] key_in;
  logic        decrypt;
  logic        next_round;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_num;
  logic        busy;
  logic        done;

  modport master (
    output key_load, key_in, decrypt, next_round,
    input  subkey, subkey_valid, round_num, busy, done
  );

  modport slave (
    input  key_load, key_in, decrypt, next_round,
    output subkey, subkey_valid, round_num, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/des_key_sched.sv
`default_nettype none
// ============================================================================
//  Module      : des_key_sched
//  Description : FIPS 46-3 DES key schedule. Holds the C/D halves and walks
//                them one round per next_round strobe, presenting PC-2(C,D)
//                as the current subkey in encrypt (K1..K16) or decrypt
//                (K16..K1) order.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_key_sched (
  input  logic            clk,
  input  logic            n_rst,
  des_key_sched_if.slave  ks
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // PC-1: FIPS key bit numbers feeding C (first 28) then D (last 28).
  localparam int c_pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: positions within the 56-bit {C,D} selected for the subkey.
  localparam int c_pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit k is set when round k shifts by two (otherwise by one).
  localparam logic [16:1] c_shift2 = 16'b0111_1110_1111_1100;

  state_t      r_state, w_state_nxt;
  logic [27:0] r_c, r_d, w_c_nxt, w_d_nxt;
  logic [3:0]  r_round, w_round_nxt;
  logic        r_dir, w_dir_nxt;

  logic [55:0] w_cd0;
  logic [27:0] w_c0, w_d0;
  logic [4:0]  w_sidx;
  logic        w_two;

  // FIPS bit b of a vector of width W sits at index W-b (bit 1 is the MSB).
  function automatic logic [55:0] f_pc1(input logic [63:0] key);
    logic [55:0] res;
    res = '0;
    for (int i = 0; i < 56; i++) begin
      res[55 - i] = key[64 - c_pc1[i]];
    end
    return res;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] cd);
    logic [47:0] res;
    res = '0;
    for (int j = 0; j < 48; j++) begin
      res[47 - j] = cd[56 - c_pc2[j]];
    end
    return res;
  endfunction

  function automatic logic [27:0] f_rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] f_rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Key permutation and per-round shift amount lookup.
  always_comb begin
    w_cd0  = f_pc1(ks.key_in);
    w_c0   = w_cd0[55:28];
    w_d0   = w_cd0[27:0];
    // Encrypt moves into round r+2; decrypt undoes round 16-r.
    w_sidx = r_dir ? (5'd16 - {1'b0, r_round}) : ({1'b0, r_round} + 5'd2);
    w_two  = c_shift2[w_sidx];
  end

  // Next-state logic: key_load takes priority over next_round in any state.
  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_d_nxt     = r_d;
    w_round_nxt = r_round;
    w_dir_nxt   = r_dir;
    if (ks.key_load) begin
      w_state_nxt = ST_ACTIVE;
      w_round_nxt = 4'd0;
      w_dir_nxt   = ks.decrypt;
      if (ks.decrypt) begin
        // Sixteen rounds total 28 shifts, so unrotated C0/D0 is K16.
        w_c_nxt = w_c0;
        w_d_nxt = w_d0;
      end else begin
        w_c_nxt = f_rotl(w_c0, 1'b0);
        w_d_nxt = f_rotl(w_d0, 1'b0);
      end
    end else begin
      case (r_state)
        ST_ACTIVE: begin
          if (ks.next_round) begin
            if (r_round == 4'd15) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_round_nxt = r_round + 4'd1;
              if (r_dir) begin
                w_c_nxt = f_rotr(r_c, w_two);
                w_d_nxt = f_rotr(r_d, w_two);
              end else begin
                w_c_nxt = f_rotl(r_c, w_two);
                w_d_nxt = f_rotl(r_d, w_two);
              end
            end
          end
        end
        ST_DONE:  w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_round <= 4'd0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_round <= w_round_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  assign ks.subkey       = f_pc2({r_c, r_d});
  assign ks.busy         = (r_state == ST_ACTIVE);
  assign ks.subkey_valid = (r_state == ST_ACTIVE);
  assign ks.done         = (r_state == ST_DONE);
  assign ks.round_num    = r_round;

endmodule
`default_nettype wire
